// File: rtl/pusch_par_scrambler.sv
// DATA_W-bit-per-clock PUSCH / msgA PUSCH scrambler with integrated Gold sequence generator.
// Optional macro PSC_PLACEHOLDER_EN adds x/y masks that force or repeat output bits for UCI.
module pusch_par_scrambler #(
    parameter int DATA_W = 8,
    parameter int NC     = 1600
) (
    input  logic              CLK_PSC,
    input  logic              RST_PSC,
    input  logic              cfg_start,
    input  logic              cfg_msga,
    input  logic [9:0]        cfg_n_id,
    input  logic [15:0]       cfg_rnti,
    input  logic [5:0]        cfg_rapid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
`ifdef PSC_PLACEHOLDER_EN
    input  logic [DATA_W-1:0] in_x_mask,
    input  logic [DATA_W-1:0] in_y_mask,
`endif
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
);

    localparam int WARM_CYC = NC / DATA_W;
    localparam int CNT_W    = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_WARMUP,
        S_RUN
    } state_t;

    state_t state_reg, state_next;

    logic              cfg_msga_reg;
    logic [9:0]        cfg_n_id_reg;
    logic [15:0]       cfg_rnti_reg;
    logic [5:0]        cfg_rapid_reg;
    logic [30:0]       c_init_next;
    logic [30:0]       x1_reg, x2_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg, out_last_reg;
    logic              accept;
    logic [DATA_W-1:0] c_bits;
    logic [DATA_W-1:0] scr_bits;

    // Register bit k of each LFSR holds x(n+k); the walk arrays unroll DATA_W steps.
    logic [30:0] x1_walk [0:DATA_W];
    logic [30:0] x2_walk [0:DATA_W];

    assign x1_walk[0] = x1_reg;
    assign x2_walk[0] = x2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_gold
            assign c_bits[gi]     = x1_walk[gi][0] ^ x2_walk[gi][0];
            assign x1_walk[gi+1]  = {x1_walk[gi][3] ^ x1_walk[gi][0], x1_walk[gi][30:1]};
            assign x2_walk[gi+1]  = {x2_walk[gi][3] ^ x2_walk[gi][2] ^ x2_walk[gi][1] ^ x2_walk[gi][0],
                                     x2_walk[gi][30:1]};
        end
    endgenerate

`ifdef PSC_PLACEHOLDER_EN
    logic last_bit_reg;

    // y repeats the previous output bit; bit 0 looks back into the previous beat.
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_scr
            logic prev_bit;
            logic s_bit;
            if (gi == 0) begin : g_first
                assign prev_bit = last_bit_reg;
            end else begin : g_rest
                assign prev_bit = g_scr[gi-1].s_bit;
            end
            assign s_bit = in_x_mask[gi] ? 1'b1 :
                           in_y_mask[gi] ? prev_bit : (in_data[gi] ^ c_bits[gi]);
            assign scr_bits[gi] = s_bit;
        end
    endgenerate
`else
    assign scr_bits = in_data ^ c_bits;
`endif

    always_comb begin
        c_init_next = {cfg_rnti_reg, 15'd0} + 31'(cfg_n_id_reg);
        if (cfg_msga_reg) begin
            c_init_next = {cfg_rnti_reg[14:0], 16'd0} + (31'(cfg_rapid_reg) << 10) + 31'(cfg_n_id_reg);
        end
    end

    assign in_ready  = (state_reg == S_RUN) && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_reg != S_IDLE);
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   state_next = S_IDLE;
            S_INIT:   state_next = S_WARMUP;
            S_WARMUP: if (cnt_reg == WARM_LAST) state_next = S_RUN;
            S_RUN:    if (accept && in_last) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        // A new configuration always wins, even over the final beat of a codeword.
        if (cfg_start) state_next = S_INIT;
    end

    always_ff @(posedge CLK_PSC) begin
        if (!RST_PSC) begin
            state_reg     <= S_IDLE;
            cfg_msga_reg  <= 1'b0;
            cfg_n_id_reg  <= '0;
            cfg_rnti_reg  <= '0;
            cfg_rapid_reg <= '0;
            x1_reg        <= '0;
            x2_reg        <= '0;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
`ifdef PSC_PLACEHOLDER_EN
            last_bit_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;

            if (cfg_start) begin
                cfg_msga_reg  <= cfg_msga;
                cfg_n_id_reg  <= cfg_n_id;
                cfg_rnti_reg  <= cfg_rnti;
                cfg_rapid_reg <= cfg_rapid;
            end

            if (state_reg == S_INIT) begin
                x1_reg  <= 31'h1;
                x2_reg  <= c_init_next;
                cnt_reg <= '0;
            end else if (state_reg == S_WARMUP) begin
                x1_reg  <= x1_walk[DATA_W];
                x2_reg  <= x2_walk[DATA_W];
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else if (accept) begin
                x1_reg  <= x1_walk[DATA_W];
                x2_reg  <= x2_walk[DATA_W];
            end

            // Output register drains independently of state so aborts keep a pending beat.
            if (accept) begin
                out_data_reg  <= scr_bits;
                out_valid_reg <= 1'b1;
                out_last_reg  <= in_last;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end

`ifdef PSC_PLACEHOLDER_EN
            if (state_reg == S_INIT) begin
                last_bit_reg <= 1'b0;
            end else if (accept) begin
                last_bit_reg <= scr_bits[DATA_W-1];
            end
`endif
        end
    end

endmodule
